// File: rtl/spi_polygon.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_polygon : polyline drawer sequencing SPI_line / SPI_horizontal edges   |
// | Optional i_abort input enabled by defining SPI_POLYGON_ABORT_EN.           |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+

module spi_frame_tx #(
    parameter int         DELAY = 2_700_000,
    parameter logic [7:0] CMD   = 8'h00,
    parameter int         NBITS = 36
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [NBITS-1:0] i_data,
    output logic             o_mosi,
    output logic             o_dc,
    output logic             o_cs,
    output logic             o_done
);
    localparam int TOTAL = NBITS + 8;
    localparam int CNT_W = $clog2(TOTAL + 1);

    typedef enum logic [1:0] {P_IDLE, P_INIT, P_SHIFT} pstate_t;
    pstate_t state_q, state_d;

    logic [TOTAL-1:0] sh_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      dly_q;
    logic             init_q;
    logic             mosi_q, dc_q, cs_q, done_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            P_IDLE:  if (i_start) state_d = init_q ? P_SHIFT : P_INIT;
            P_INIT:  if (dly_q <= 32'd1) state_d = P_SHIFT;
            P_SHIFT: if (cnt_q == '0) state_d = P_IDLE;
            default: state_d = P_IDLE;
        endcase
    end

    // The init delay is paid only by the first frame after reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= P_IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            dly_q   <= '0;
            init_q  <= 1'b0;
            mosi_q  <= 1'b0;
            dc_q    <= 1'b0;
            cs_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            case (state_q)
                P_IDLE: begin
                    if (i_start) begin
                        sh_q  <= {CMD, i_data};
                        cnt_q <= CNT_W'(TOTAL);
                        dly_q <= 32'(DELAY);
                    end
                end
                P_INIT: begin
                    if (dly_q != 32'd0) dly_q <= dly_q - 32'd1;
                    if (dly_q <= 32'd1) init_q <= 1'b1;
                end
                P_SHIFT: begin
                    if (cnt_q != '0) begin
                        mosi_q <= sh_q[TOTAL-1];
                        dc_q   <= (cnt_q <= CNT_W'(NBITS));
                        cs_q   <= 1'b0;
                        sh_q   <= {sh_q[TOTAL-2:0], 1'b0};
                        cnt_q  <= cnt_q - 1'b1;
                    end else begin
                        mosi_q <= 1'b0;
                        dc_q   <= 1'b0;
                        cs_q   <= 1'b1;
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_mosi = mosi_q;
    assign o_dc   = dc_q;
    assign o_cs   = cs_q;
    assign o_done = done_q;
endmodule

module SPI_line #(
    parameter int DELAY   = 2_700_000,
    parameter int COORD_W = 9
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [COORD_W-1:0] i_x1,
    input  logic [COORD_W-1:0] i_y1,
    input  logic [COORD_W-1:0] i_x2,
    input  logic [COORD_W-1:0] i_y2,
    output logic               o_mosi,
    output logic               o_dc,
    output logic               o_cs,
    output logic               o_done
);
    spi_frame_tx #(.DELAY(DELAY), .CMD(8'h4C), .NBITS(4*COORD_W)) u_tx (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
        .i_data({i_x1, i_y1, i_x2, i_y2}),
        .o_mosi(o_mosi), .o_dc(o_dc), .o_cs(o_cs), .o_done(o_done)
    );
endmodule

module SPI_horizontal #(
    parameter int DELAY   = 2_700_000,
    parameter int COORD_W = 9
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [COORD_W-1:0] i_x1,
    input  logic [COORD_W-1:0] i_x2,
    input  logic [COORD_W-1:0] i_y,
    output logic               o_mosi,
    output logic               o_dc,
    output logic               o_cs,
    output logic               o_done
);
    spi_frame_tx #(.DELAY(DELAY), .CMD(8'h48), .NBITS(3*COORD_W)) u_tx (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
        .i_data({i_x1, i_x2, i_y}),
        .o_mosi(o_mosi), .o_dc(o_dc), .o_cs(o_cs), .o_done(o_done)
    );
endmodule

module spi_polygon #(
    parameter int DELAY     = 2_700_000,
    parameter int MAX_VERTS = 8,
    parameter int AW        = 3,
    parameter int COORD_W   = 9
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_wr_en,
    input  logic [AW-1:0]      i_wr_addr,
    input  logic [COORD_W-1:0] i_wr_x,
    input  logic [COORD_W-1:0] i_wr_y,
    input  logic [AW:0]        i_num_verts,
    input  logic               i_closed,
    input  logic               i_start,
`ifdef SPI_POLYGON_ABORT_EN
    input  logic               i_abort,
`endif
    output logic               o_busy,
    output logic               o_mosi,
    output logic               o_dc,
    output logic               o_cs,
    output logic               o_done
);
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LAUNCH, S_WAIT, S_FINISH} state_t;
    state_t state_q, state_d;

    logic [COORD_W-1:0] vx_q [MAX_VERTS];
    logic [COORD_W-1:0] vy_q [MAX_VERTS];
    logic [AW:0]        n_q, e_q, k_q;
    logic [COORD_W-1:0] ax_q, ay_q, bx_q, by_q;
    logic               horiz_q, busy_q, done_q, abort_pend_q;

    logic [AW:0]        n_clamp, e_calc, k_next;
    logic [AW-1:0]      idx_a, idx_b;
    logic [COORD_W-1:0] hx1, hx2;
    logic               abort_req, launch, sel_done, active;
    logic               l_mosi, l_dc, l_cs, l_done;
    logic               h_mosi, h_dc, h_cs, h_done;

`ifdef SPI_POLYGON_ABORT_EN
    assign abort_req = i_abort;
`else
    assign abort_req = 1'b0;
`endif

    assign n_clamp = (i_num_verts > (AW+1)'(MAX_VERTS)) ? (AW+1)'(MAX_VERTS) : i_num_verts;
    assign e_calc  = (n_clamp < (AW+1)'(2))  ? '0 :
                     (n_clamp == (AW+1)'(2)) ? (AW+1)'(1) :
                     n_clamp - 1'b1 + {{AW{1'b0}}, i_closed};
    assign k_next  = k_q + 1'b1;
    assign idx_a   = k_q[AW-1:0];
    assign idx_b   = (k_next == n_q) ? '0 : k_next[AW-1:0];
    assign hx1     = (ax_q < bx_q) ? ax_q : bx_q;
    assign hx2     = (ax_q < bx_q) ? bx_q : ax_q;
    assign sel_done = horiz_q ? h_done : l_done;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (i_start) state_d = (e_calc == '0) ? S_FINISH : S_SETUP;
            S_SETUP:  state_d = abort_req ? S_FINISH : S_LAUNCH;
            S_LAUNCH: state_d = abort_req ? S_FINISH : S_WAIT;
            S_WAIT: begin
                if (sel_done)
                    state_d = (k_next == e_q || abort_pend_q || abort_req) ? S_FINISH : S_SETUP;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        launch = (state_q == S_LAUNCH) && !abort_req;
        active = (state_q == S_LAUNCH) || (state_q == S_WAIT);
        o_mosi = 1'b0;
        o_dc   = 1'b0;
        o_cs   = 1'b1;
        if (active) begin
            o_mosi = horiz_q ? h_mosi : l_mosi;
            o_dc   = horiz_q ? h_dc   : l_dc;
            o_cs   = horiz_q ? h_cs   : l_cs;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            n_q          <= '0;
            e_q          <= '0;
            k_q          <= '0;
            ax_q         <= '0;
            ay_q         <= '0;
            bx_q         <= '0;
            by_q         <= '0;
            horiz_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            abort_pend_q <= 1'b0;
            for (int i = 0; i < MAX_VERTS; i++) begin
                vx_q[i] <= '0;
                vy_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            // Registered so the pulse lands in the cycle after FINISH, with busy already low.
            done_q  <= (state_q == S_FINISH);
            case (state_q)
                S_IDLE: begin
                    if (i_wr_en && ({1'b0, i_wr_addr} < (AW+1)'(MAX_VERTS))) begin
                        vx_q[i_wr_addr] <= i_wr_x;
                        vy_q[i_wr_addr] <= i_wr_y;
                    end
                    if (i_start) begin
                        n_q          <= n_clamp;
                        e_q          <= e_calc;
                        k_q          <= '0;
                        busy_q       <= 1'b1;
                        abort_pend_q <= 1'b0;
                    end
                end
                S_SETUP: begin
                    ax_q    <= vx_q[idx_a];
                    ay_q    <= vy_q[idx_a];
                    bx_q    <= vx_q[idx_b];
                    by_q    <= vy_q[idx_b];
                    horiz_q <= (vy_q[idx_a] == vy_q[idx_b]);
                end
                S_WAIT: begin
                    if (abort_req) abort_pend_q <= 1'b1;
                    if (sel_done)  k_q <= k_next;
                end
                S_FINISH: busy_q <= 1'b0;
                default: ;
            endcase
        end
    end

    SPI_line #(.DELAY(DELAY), .COORD_W(COORD_W)) u_line (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(launch && !horiz_q),
        .i_x1(ax_q), .i_y1(ay_q), .i_x2(bx_q), .i_y2(by_q),
        .o_mosi(l_mosi), .o_dc(l_dc), .o_cs(l_cs), .o_done(l_done)
    );

    SPI_horizontal #(.DELAY(DELAY), .COORD_W(COORD_W)) u_horiz (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(launch && horiz_q),
        .i_x1(hx1), .i_x2(hx2), .i_y(ay_q),
        .o_mosi(h_mosi), .o_dc(h_dc), .o_cs(h_cs), .o_done(h_done)
    );

    assign o_busy = busy_q;
    assign o_done = done_q;
endmodule
`default_nettype wire
